// File: rtl/bram_line_buffer_pkg.sv
// Shared constants and small pointer helpers for the multi-row line buffer.
//   DEF_*      : default parameter values for the buffer
//   RD_STAGES  : read latency in cycles (BRAM read + rotate register)
//   wrap_inc   : (p + 1) mod n for p < n
//   wrap_add   : (a + b) mod n for a, b < n
package bram_line_buffer_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ROWS          = 3;
  localparam int DEF_MAX_ROW_WIDTH = 1024;
  localparam int RD_STAGES         = 2;

  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned n);
    return (p + 1 >= n) ? 0 : p + 1;
  endfunction

  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/bram_line_buffer_sdp.sv
// Simple dual-port RAM: one write port, one synchronous read port.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata valid the cycle after re, held otherwise
module bram_line_buffer_sdp #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 1024,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // No reset: contents and read register are plain block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_line_buffer.sv
// Multi-row line buffer: ROWS rows of run-time width, one BRAM per row.
// Pixels stream in with valid/ready; a read returns one column of every
// row, rotated so slot 0 is the oldest row. row_pop retires the oldest row
// so the next incoming row refills its slot without touching the others.
//   clk, rst (async, active low), flush (sync clear, BRAM untouched)
//   row_width           : words per row, latched only while empty
//   in_data/in_valid/in_ready : pixel write stream
//   rd_en/rd_addr       : column read, accepted only when full
//   row_pop             : retire oldest complete row
//   out_data/out_valid  : column result, 2 cycles after acceptance
//   rows_filled/full/empty : occupancy status
module bram_line_buffer
  import bram_line_buffer_pkg::*;
#(
  parameter  int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter  int ROWS          = DEF_ROWS,
  parameter  int MAX_ROW_WIDTH = DEF_MAX_ROW_WIDTH,
  localparam int AW            = $clog2(MAX_ROW_WIDTH),
  localparam int RW            = $clog2(ROWS + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [AW:0]                row_width,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       rd_en,
  input  logic [AW-1:0]              rd_addr,
  input  logic                       row_pop,
  output logic [ROWS*DATA_WIDTH-1:0] out_data,
  output logic                       out_valid,
  output logic [RW-1:0]              rows_filled,
  output logic                       full,
  output logic                       empty
);

  localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int WW = AW + 1;

  logic [WW-1:0]                  width_q, width_sel;
  logic [AW-1:0]                  wr_col;
  logic [PW-1:0]                  wr_row, head, head_cap;
  logic [RW-1:0]                  fill_q;
  logic [RD_STAGES:1]             vld_pipe;
  logic [ROWS-1:0][DATA_WIDTH-1:0] rd_q, rot;
  logic                           wr_fire, last_col, row_done, pop_fire, rd_fire;

  assign full        = (fill_q == RW'(ROWS));
  assign empty       = (fill_q == '0) && (wr_col == '0);
  assign in_ready    = !full;
  assign rows_filled = fill_q;
  assign out_valid   = vld_pipe[RD_STAGES];

  // Out-of-range widths fall back to the full BRAM depth.
  assign width_sel = (row_width == '0 || row_width > WW'(MAX_ROW_WIDTH))
                   ? WW'(MAX_ROW_WIDTH) : row_width;

  assign wr_fire  = in_valid && !full && !flush;
  assign last_col = ({1'b0, wr_col} == width_q - WW'(1));
  assign row_done = wr_fire && last_col;
  assign pop_fire = row_pop && (fill_q != '0) && !flush;
  assign rd_fire  = rd_en && full && ({1'b0, rd_addr} < width_q) && !flush;

  // Reads require full and writes require !full, so a bank is never
  // read and written in the same cycle.
  for (genvar i = 0; i < ROWS; i++) begin : g_row
    bram_line_buffer_sdp #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (MAX_ROW_WIDTH)
    ) u_bram (
      .clk   (clk),
      .we    (wr_fire && (wr_row == PW'(i))),
      .waddr (wr_col),
      .wdata (in_data),
      .re    (rd_fire),
      .raddr (rd_addr),
      .rdata (rd_q[i])
    );
  end

  // Slot k takes physical row (head_cap + k) mod ROWS.
  always_comb begin
    logic [PW-1:0] sel;
    sel = '0;
    rot = '0;
    for (int unsigned k = 0; k < ROWS; k++) begin
      sel    = PW'(wrap_add(32'(head_cap), k, ROWS));
      rot[k] = rd_q[sel];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      width_q  <= WW'(MAX_ROW_WIDTH);
      wr_col   <= '0;
      wr_row   <= '0;
      head     <= '0;
      head_cap <= '0;
      fill_q   <= '0;
      vld_pipe <= '0;
      out_data <= '0;
    end else if (flush) begin
      // width_q is left alone here; it re-latches next cycle since empty.
      wr_col   <= '0;
      wr_row   <= '0;
      head     <= '0;
      head_cap <= '0;
      fill_q   <= '0;
      vld_pipe <= '0;
      out_data <= '0;
    end else begin
      if (empty) width_q <= width_sel;

      if (wr_fire) begin
        if (last_col) begin
          wr_col <= '0;
          wr_row <= PW'(wrap_inc(32'(wr_row), ROWS));
        end else begin
          wr_col <= wr_col + AW'(1);
        end
      end

      if (pop_fire) head <= PW'(wrap_inc(32'(head), ROWS));

      // Completion and pop in the same cycle cancel out.
      case ({row_done, pop_fire})
        2'b10:   fill_q <= fill_q + RW'(1);
        2'b01:   fill_q <= fill_q - RW'(1);
        default: ;
      endcase

      // head is sampled at acceptance so a concurrent pop cannot skew the result.
      if (rd_fire) head_cap <= head;
      vld_pipe <= {vld_pipe[RD_STAGES-1:1], rd_fire};
      if (vld_pipe[1]) out_data <= rot;
    end
  end

endmodule
